dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_array.sv | 29 ++
 rtl/dmem_responder.sv | 170 +++++++++++++++++
 tb/tb_dmem_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
// Holds the FSM state encoding, data widths and default build parameters.
package dmem_pkg;

    localparam int WORD_W              = 32;
    localparam int BE_W                = 4;
    localparam int CNT_W               = 4;
    localparam int DEFAULT_DEPTH_WORDS = 1024;
    localparam int DEFAULT_WAIT_CYCLES = 2;

    localparam logic [CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 4'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_t;

    // Byte-lane merge: lanes with be set take new_word, the rest keep old_word.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-enabled synchronous write port, combinational read port.
// Contents are deliberately never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

    // Byte-lane write, committed on the rising edge when we is set.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[waddr] <= merge_bytes(mem_r[waddr], wdata, be);
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts a request in IDLE, inserts
// WAIT_CYCLES wait states, then emits a one-cycle response with read data or error.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [BE_W-1:0]   req_be,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int               IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic             ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT  = ZERO_WAIT ? CNT_ZERO : CNT_W'(WAIT_CYCLES - 1);

    dmem_state_t       state_r;
    dmem_state_t       state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;

    logic              we_r;
    logic [BE_W-1:0]   be_r;
    logic [31:0]       addr_r;
    logic [WORD_W-1:0] wdata_r;

    logic              accept_s;
    logic              enter_resp_s;
    logic              cur_we_s;
    logic [BE_W-1:0]   cur_be_s;
    logic [31:0]       cur_addr_s;
    logic [WORD_W-1:0] cur_wdata_s;
    logic [IDX_W-1:0]  idx_s;
    logic              in_range_s;
    logic              arr_we_s;
    logic [WORD_W-1:0] arr_rdata_s;

    logic              rsp_valid_r;
    logic [WORD_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    // Ready is held low during the reset cycle even though the state is already IDLE.
    assign req_ready = (state_r == ST_IDLE) && !resetn;
    assign accept_s  = req_valid && req_ready;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ZERO_WAIT ? ST_RESP : ST_WAIT;
                    cnt_nxt_s   = CNT_INIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_RESP;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = cnt_r - CNT_ONE;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // A zero-wait build enters RESP straight from IDLE, so the live request feeds
    // the array on that edge instead of the not-yet-loaded latch.
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_we_s    = req_we;
            cur_be_s    = req_be;
            cur_addr_s  = req_addr;
            cur_wdata_s = req_wdata;
        end else begin
            cur_we_s    = we_r;
            cur_be_s    = be_r;
            cur_addr_s  = addr_r;
            cur_wdata_s = wdata_r;
        end
    end

    assign idx_s        = cur_addr_s[IDX_W+1:2];
    assign in_range_s   = ((cur_addr_s >> (IDX_W + 2)) == 32'd0);
    assign enter_resp_s = !resetn && (state_nxt_s == ST_RESP) && (state_r != ST_RESP);
    assign arr_we_s     = enter_resp_s && cur_we_s && in_range_s;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clock (clock),
        .we    (arr_we_s),
        .be    (cur_be_s),
        .waddr (idx_s),
        .wdata (cur_wdata_s),
        .raddr (idx_s),
        .rdata (arr_rdata_s)
    );

    // State and wait-counter registers.
    always_ff @(posedge clock) begin
        if (resetn) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Request latch, loaded on acceptance and cleared by reset.
    always_ff @(posedge clock) begin
        if (resetn) begin
            we_r    <= 1'b0;
            be_r    <= 4'b0000;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
        end else if (accept_s) begin
            we_r    <= req_we;
            be_r    <= req_be;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
        end
    end

    // Response registers: populated only on the edge entering RESP, zero elsewhere.
    always_ff @(posedge clock) begin
        if (resetn) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else if (enter_resp_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= (!cur_we_s && in_range_s) ? arr_rdata_s : 32'd0;
            rsp_err_r   <= !in_range_s;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized bench for dmem_responder (WAIT_CYCLES=2 and a zero-wait
// instance), checked against a word-array reference model.
module tb_dmem_responder;

    localparam int W = 2;

    logic        clock = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [3:0]  z_req_be;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [1024];

    always #5 clock = ~clock;

    dmem_responder #(.WAIT_CYCLES(W), .DEPTH_WORDS(1024)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) dut0 (
        .clock(clock), .resetn(resetn),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_be(z_req_be), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT_CYCLES=2 instance; caller is at a negedge with DUT idle.
    task automatic do_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag);
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [31:0] mask;
        int          idx;
        int          lat;
        exp_err   = (addr >= 32'h0000_1000);
        idx       = int'(addr[11:2]);
        exp_rdata = (!exp_err && !we) ? model[idx] : 32'd0;
        mask      = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clock);
        if (!exp_err && we) model[idx] = (model[idx] & ~mask) | (wdata & mask);
        lat = 0;
        do begin
            @(negedge clock);
            req_valid = 1'b0;
            req_addr  = $urandom();
            req_we    = 1'($urandom());
            lat++;
            check({tag, "_busy_ready"}, {31'd0, req_ready}, 32'd0);
        end while (!rsp_valid && lat < 20);
        check({tag, "_latency"}, 32'(lat), 32'(W + 1));
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        @(negedge clock);
        check({tag, "_pulse_end"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        check({tag, "_idle_rdata"}, rsp_rdata | {31'd0, rsp_err}, 32'd0);
    endtask

    initial begin
        int acc;
        int pulses;
        logic [31:0] a;
        resetn = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'd0; req_wdata = 32'd0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_be = 4'h0; z_req_addr = 32'd0; z_req_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_ready", {31'd0, req_ready}, 32'd0);
        check("reset_rsp", {31'd0, rsp_valid} | {31'd0, rsp_err} | rsp_rdata, 32'd0);
        resetn = 1'b0;
        @(negedge clock);
        check("post_reset_ready", {31'd0, req_ready}, 32'd1);

        // Full write/read, partial lanes, empty byte enable
        do_txn(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, "wr10");
        do_txn(1'b0, 4'h0, 32'h10, 32'h0, "rd10");
        check("rd10_const", model[4], 32'hDEADBEEF);
        do_txn(1'b1, 4'hF, 32'h20, 32'h11223344, "wr20");
        do_txn(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, "wr20_be");
        do_txn(1'b0, 4'hF, 32'h23, 32'h0, "rd20");
        check("rd20_const", model[8], 32'h11BB33DD);
        do_txn(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, "wr10_be0");
        do_txn(1'b0, 4'h0, 32'h10, 32'h0, "rd10_be0");

        // Out-of-range read/write must not alias onto word 0
        do_txn(1'b1, 4'hF, 32'h0, 32'h5A5A1234, "wr0");
        do_txn(1'b0, 4'h0, 32'h1000, 32'h0, "rd1000");
        do_txn(1'b1, 4'hF, 32'h1000, 32'hFFFF0000, "wr1000");
        do_txn(1'b1, 4'hF, 32'h8000_0000, 32'h0F0F0F0F, "wr_top");
        do_txn(1'b0, 4'h0, 32'h0, 32'h0, "rd0");

        // Held req_valid: one acceptance per W+2 cycles
        acc = 0; pulses = 0;
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            check("hold_ready", {31'd0, req_ready}, {31'd0, (k % (W + 2)) == 0});
            check("hold_rsp", {31'd0, rsp_valid}, {31'd0, (k % (W + 2)) == (W + 1)});
            if (req_ready) acc++;
            if (rsp_valid) begin
                pulses++;
                check("hold_rdata", rsp_rdata, model[4]);
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clock);
        end
        check("hold_accepts", 32'(acc), 32'd5);
        check("hold_pulses", 32'(pulses), 32'd5);

        // Reset one cycle after an accepted write abandons it
        do_txn(1'b1, 4'hF, 32'h30, 32'h0BADC0DE, "wr30_old");
        req_we = 1'b1; req_be = 4'hF; req_addr = 32'h30; req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        resetn = 1'b1;
        @(negedge clock);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
        resetn = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid) pulses++;
            @(negedge clock);
        end
        check("rst_no_rsp", 32'(pulses), 32'd0);
        do_txn(1'b0, 4'h0, 32'h30, 32'h0, "rd30");

        // Zero-wait instance: respond at t+1, next accept at t+2
        z_req_we = 1'b1; z_req_be = 4'hF; z_req_addr = 32'h40; z_req_wdata = 32'hCAFEF00D; z_req_valid = 1'b1;
        check("z_ready", {31'd0, z_req_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        z_req_valid = 1'b0;
        check("z_wr_rsp", {30'd0, z_rsp_valid, z_rsp_err}, 32'd2);
        check("z_wr_rdata", z_rsp_rdata, 32'd0);
        @(negedge clock);
        check("z_wr_end", {30'd0, z_rsp_valid, z_req_ready}, 32'd1);
        z_req_we = 1'b0; z_req_addr = 32'h41; z_req_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("z_rd1", {30'd0, z_rsp_valid, z_req_ready}, 32'd2);
        check("z_rd1_data", z_rsp_rdata, 32'hCAFEF00D);
        @(negedge clock);
        check("z_rd_gap", {30'd0, z_rsp_valid, z_req_ready}, 32'd1);
        @(negedge clock);
        z_req_valid = 1'b0;
        check("z_rd2", {30'd0, z_rsp_valid, z_req_ready}, 32'd2);
        check("z_rd2_data", z_rsp_rdata, 32'hCAFEF00D);
        @(negedge clock);

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) do_txn(1'b1, 4'hF, 32'(i * 4), $urandom(), "rnd_init");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) a = $urandom() | (32'd1 << $urandom_range(31, 12));
            else a = {26'd0, 4'($urandom_range(15)), 2'($urandom())};
            do_txn(1'($urandom()), 4'($urandom()), a, $urandom(), "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
